// File: rtl/pwm_dec_pkg.sv
// rtl/pwm_dec_pkg.sv - shared types and constants for the PWM capture/decoder tile
// Purpose: FSM state encoding, pin field indices and divider constants
//          used by tt_um_pwm_decoder and pwm_duty_div.
// Ports:   none (package).
package pwm_dec_pkg;

  typedef enum logic [1:0] {
    ST_ARM  = 2'd0,
    ST_WAIT = 2'd1,
    ST_DIV  = 2'd2,
    ST_TOUT = 2'd3
  } dec_state_t;

  // ui_in fields
  localparam int UI_PWM = 0;
  localparam int UI_CLR = 1;

  // uo_out fields
  localparam int UO_DUTY_LSB = 0;
  localparam int UO_DUTY_W   = 4;
  localparam int UO_VALID    = 4;
  localparam int UO_TOUT     = 5;
  localparam int UO_OVR      = 6;
  localparam int UO_LEVEL    = 7;

  // Duty is reported in tenths; the quotient needs 4 bits, one per divide step.
  localparam int DUTY_SCALE = 10;
  localparam int DIV_STEPS  = 4;

endpackage

// File: rtl/pwm_duty_div.sv
// rtl/pwm_duty_div.sv - 4-step restoring divider computing round(10*h/p)
// Purpose: on start, latches N = 10*h + p/2 and D = p, then resolves one
//          quotient bit per cycle (k = 3..0).
// Ports:   clk, rst_n     - clock, async active-low reset
//          start          - load operands (one-cycle pulse)
//          h, p           - high time and period (h <= p, p >= 1)
//          busy           - divide in progress
//          q              - quotient; final value is valid while done=1
//          done           - high during the last step cycle
import pwm_dec_pkg::*;

module pwm_duty_div #(
  parameter int CNT_W = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] h,
  input  logic [CNT_W-1:0] p,
  output logic             busy,
  output logic [3:0]       q,
  output logic             done
);

  localparam int N_W = CNT_W + 4;

  logic [N_W-1:0]   n_r;
  logic [N_W-1:0]   n_init;
  logic [N_W-1:0]   dk;
  logic [CNT_W-1:0] d_r;
  logic [1:0]       k_r;
  logic [3:0]       q_r;
  logic             ge;

  // q includes the bit resolved in the current step, so the caller can
  // commit the final quotient in the same cycle that done is high.
  always_comb begin
    n_init = N_W'(h) * N_W'(DUTY_SCALE) + N_W'(p >> 1);
    dk     = N_W'(d_r) << k_r;
    ge     = (n_r >= dk);
    q      = q_r | (ge ? (4'b0001 << k_r) : 4'b0000);
    done   = busy && (k_r == 2'd0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n_r  <= '0;
      d_r  <= '0;
      k_r  <= 2'd0;
      q_r  <= 4'd0;
      busy <= 1'b0;
    end else if (start) begin
      n_r  <= n_init;
      d_r  <= p;
      k_r  <= 2'(DIV_STEPS - 1);
      q_r  <= 4'd0;
      busy <= 1'b1;
    end else if (busy) begin
      if (ge) begin
        n_r <= n_r - dk;
      end
      q_r <= q;
      if (k_r == 2'd0) begin
        busy <= 1'b0;
      end else begin
        k_r <= k_r - 2'd1;
      end
    end
  end

endmodule

// File: rtl/tt_um_pwm_decoder.sv
// rtl/tt_um_pwm_decoder.sv - PWM capture tile reporting duty (tenths) and period
// Purpose: synchronises pwm_in, measures rise-to-rise period and high time,
//          divides to a duty in tenths, flags timeout and overrun.
// Ports:   ui_in[0] pwm_in, ui_in[1] clr_flags
//          uo_out   {level, overrun, timeout, valid, duty[3:0]}
//          uio_out  measured period saturated to 255; uio_oe = 8'hFF
//          uio_in, ena unused; clk, rst_n (async active-low)
import pwm_dec_pkg::*;

module tt_um_pwm_decoder #(
  parameter int CNT_W = 12
) (
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe,
  input  logic       ena,
  input  logic       clk,
  input  logic       rst_n
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             sync1;
  logic             level;
  logic             prev;
  logic             rise;
  logic             clr_flags;

  logic [CNT_W-1:0] pc;
  logic [CNT_W-1:0] hc;
  logic [CNT_W-1:0] p_cap;
  logic             pc_sat;

  dec_state_t       state;
  dec_state_t       state_nxt;
  logic             div_start;
  logic             ovr_set;
  logic             commit;
  logic             tout_enter;

  logic             div_busy;
  logic             div_done;
  logic [3:0]       div_q;

  logic [3:0]       duty_r;
  logic             valid_r;
  logic             tout_r;
  logic             ovr_r;
  logic [7:0]       per_r;

  logic             unused_pins;
  assign unused_pins = &{1'b0, ena, uio_in, ui_in[7:2], div_busy};

  assign clr_flags = ui_in[UI_CLR];
  assign rise      = level & ~prev;
  assign pc_sat    = (pc == CNT_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      level <= 1'b0;
      prev  <= 1'b0;
    end else begin
      sync1 <= ui_in[UI_PWM];
      level <= sync1;
      prev  <= level;
    end
  end

  // Both counters restart at 1 on a rise: the rise cycle is already the first
  // (high) cycle of the new window, so H <= P always holds at capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= '0;
      hc <= '0;
    end else if (rise) begin
      pc <= CNT_W'(1);
      hc <= CNT_W'(1);
    end else begin
      if (!pc_sat) begin
        pc <= pc + CNT_W'(1);
      end
      if (level && (hc != CNT_MAX)) begin
        hc <= hc + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_ARM;
      p_cap <= '0;
    end else begin
      state <= state_nxt;
      if (div_start) begin
        p_cap <= pc;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    div_start = 1'b0;
    ovr_set   = 1'b0;
    commit    = 1'b0;
    unique case (state)
      ST_ARM: begin
        if (rise) begin
          state_nxt = ST_WAIT;
        end else if (pc_sat) begin
          state_nxt = ST_TOUT;
        end
      end
      ST_WAIT: begin
        if (rise) begin
          state_nxt = ST_DIV;
          div_start = 1'b1;
        end else if (pc_sat) begin
          state_nxt = ST_TOUT;
        end
      end
      ST_DIV: begin
        // A rise here is dropped; the counters still restart on it.
        ovr_set = rise;
        if (div_done) begin
          commit    = 1'b1;
          state_nxt = ST_WAIT;
        end
      end
      ST_TOUT: begin
        if (rise) begin
          state_nxt = ST_ARM;
        end
      end
      default: state_nxt = ST_ARM;
    endcase
    tout_enter = (state_nxt == ST_TOUT) && (state != ST_TOUT);
  end

  pwm_duty_div #(
    .CNT_W (CNT_W)
  ) u_div (
    .clk   (clk),
    .rst_n (rst_n),
    .start (div_start),
    .h     (hc),
    .p     (pc),
    .busy  (div_busy),
    .q     (div_q),
    .done  (div_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      duty_r  <= 4'd0;
      valid_r <= 1'b0;
      tout_r  <= 1'b0;
      per_r   <= 8'd0;
    end else if (tout_enter) begin
      tout_r <= 1'b1;
      duty_r <= level ? 4'(DUTY_SCALE) : 4'd0;
      per_r  <= 8'hFF;
    end else if (commit) begin
      duty_r  <= div_q;
      per_r   <= (p_cap > CNT_W'(255)) ? 8'hFF : p_cap[7:0];
      valid_r <= 1'b1;
      tout_r  <= 1'b0;
    end
  end

  // Set wins over a simultaneous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovr_r <= 1'b0;
    end else if (ovr_set) begin
      ovr_r <= 1'b1;
    end else if (clr_flags) begin
      ovr_r <= 1'b0;
    end
  end

  always_comb begin
    uo_out = 8'd0;
    uo_out[UO_DUTY_LSB +: UO_DUTY_W] = duty_r;
    uo_out[UO_VALID]                 = valid_r;
    uo_out[UO_TOUT]                  = tout_r;
    uo_out[UO_OVR]                   = ovr_r;
    uo_out[UO_LEVEL]                 = level;
  end

  assign uio_out = per_r;
  assign uio_oe  = 8'hFF;

endmodule
